f_fetch_unit: RTL
=================

Name: f_fetch_unit

Overview:
- Producer side of the F→D pipeline-register interface; fetch stage of the P7 MIPS pipeline.
- Owns the PC register and drives the instruction-memory address.
- Presents F_PC, F_instr, F_excCode and F_BD to the F/D register.
- Obeys the same Stall and Req (exception flush) controls the F/D register uses, and handles ERET and D-stage branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry, loaded on Req.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard stall; hold PC, same signal that freezes the F/D register.
- Req  in  1  exception/interrupt request from CP0; flush and redirect to HANDLER_PC.
- D_eret  in  1  ERET currently decoded in D.
- EPC  in  32  CP0 EPC value (already forwarded).
- D_redirect  in  1  D-stage branch taken or jump.
- D_target  in  32  redirect target address.
- D_is_bj  in  1  instruction in D is a branch/jump (so F holds its delay slot).
- i_inst_rdata  in  32  instruction-memory read data (combinational read of i_inst_addr).
- i_inst_addr  out  32  instruction-memory address, equals F_PC.
- F_PC  out  32  current fetch PC.
- F_instr  out  32  fetched instruction, or 0 when squashed/faulted.
- F_excCode  out  5  0 = none, 4 = AdEL (fetch).
- F_BD  out  1  fetched instruction is in a branch delay slot.

Behaviour:
- PC register (pc_q) is the only architectural state, plus a 1-bit squash flag (sq_q).
- Asynchronous reset: pc_q = RESET_PC, sq_q = 0, immediately on reset assertion.
- Next-PC priority, per rising edge:
  - Req: pc_q ← HANDLER_PC, sq_q ← 0. Req overrides Stall, D_eret and D_redirect.
  - D_eret && !Stall: pc_q ← EPC, sq_q ← 0.
  - Stall: pc_q and sq_q hold.
  - D_redirect: pc_q ← D_target.
  - Otherwise: pc_q ← pc_q + 4, wrapping modulo 2^32 with no trap.
- Outputs are combinational from pc_q: F_PC = i_inst_addr = pc_q.
- Address check on pc_q:
  - Fault if pc_q[1:0] ≠ 0, or pc_q < IM_BASE, or pc_q > IM_LIMIT.
  - On fault: F_excCode = 4 and F_instr = 0. F_PC still reports the faulting pc_q so CP0 records the correct EPC.
- ERET squash: while D_eret = 1, F_instr = 0 and F_excCode = 0. ERET has no delay slot; this applies even during Stall.
- F_BD = D_is_bj && !D_eret.
- Req asserted mid-stall: handler redirect still occurs on that edge; Stall is ignored.
- Reset asserted while Req is asserted: reset wins; pc_q = RESET_PC.
- sq_q is reserved for a registered squash; ERET squash is combinational.
- Latency:
  - Redirect decided in D takes effect on the next edge; the delay-slot instruction is already in F and proceeds.
  - ERET costs one bubble.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two 32-bit counters plus ports perf_fetch[31:0] and perf_stall[31:0] (outputs).
  - perf_fetch increments on each edge with !Stall && !Req && !D_eret && no fault.
  - perf_stall increments on each edge with Stall && !Req.
  - Both clear on async reset and wrap at 2^32.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - EXC_NONE = 5'd0, EXC_ADEL = 5'd4.
  - RESET_PC and HANDLER_PC defaults, also used by the F/D register and CP0.
- Sub-module f_addr_check (combinational): inputs pc, IM_BASE, IM_LIMIT; output fault.

Test Plan:
- Release reset, no stalls, 3 edges → F_PC = 0x3000, 0x3004, 0x3008, 0x300C; F_instr tracks i_inst_rdata.
- Stall = 1 for 2 edges at PC 0x3010 → F_PC stays 0x3010; on release the next edge gives 0x3014.
- D_is_bj = 1, D_redirect = 1, D_target = 0x3100 at PC 0x3008 → F_BD = 1 that cycle; next F_PC = 0x3100 with F_BD = 0.
- Req = 1 together with Stall = 1 and D_redirect = 1 → next F_PC = 0x4180, F_excCode = 0.
- D_eret = 1, EPC = 0x3020 → F_instr = 0 that cycle; next F_PC = 0x3020. Repeat with EPC = 0x3022 → next cycle F_excCode = 4, F_instr = 0, F_PC = 0x3022.
- Assert reset asynchronously mid-cycle at PC 0x3044 → F_PC = 0x3000 before the next clock edge. With FETCH_PERF_EN, perf_fetch and perf_stall read 0 at that point.

Source files
------------

// File: rtl/f_fetch_unit_pkg.sv
// Shared fetch/exception constants, also used by the F/D register and CP0.
// Holds exception codes and the default reset and handler entry addresses.
package f_fetch_unit_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DFLT = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DFLT    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_DFLT   = 32'h0000_6FFC;

endpackage

// File: rtl/f_addr_check.sv
// Fetch address legality check: word alignment and the [im_base, im_limit] window.
// Purely combinational, no state and no flow control.
module f_addr_check (
  input  logic [31:0] pc,
  input  logic [31:0] im_base,
  input  logic [31:0] im_limit,
  output logic        fault
);

  assign fault = (pc[1:0] != 2'b00) || (pc < im_base) || (pc > im_limit);

endmodule

// File: rtl/f_fetch_unit.sv
// MIPS fetch stage: PC register, next-PC select, AdEL check and ERET squash.
// Outputs are combinational from pc_q; Stall holds the PC, Req overrides it. FETCH_PERF_EN adds counters.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DFLT,
  parameter logic [31:0] IM_BASE    = IM_BASE_DFLT,
  parameter logic [31:0] IM_LIMIT   = IM_LIMIT_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_redirect,
  input  logic [31:0] D_target,
  input  logic        D_is_bj,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic [4:0]  F_excCode,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
`endif
  output logic        F_BD
);

  logic [31:0] pc_q, pc_d;
  logic        sq_q, sq_d;
  logic        fault;
  logic        squash;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      sq_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      sq_q <= sq_d;
    end
  end

  // Req beats everything; a stalled ERET waits for the stall to clear.
  always_comb begin
    pc_d = pc_q + 32'd4;
    sq_d = 1'b0;
    if (Req) begin
      pc_d = HANDLER_PC;
    end else if (D_eret && !Stall) begin
      pc_d = EPC;
    end else if (Stall) begin
      pc_d = pc_q;
      sq_d = sq_q;
    end else if (D_redirect) begin
      pc_d = D_target;
    end
  end

  f_addr_check u_addr_check (
    .pc       (pc_q),
    .im_base  (IM_BASE),
    .im_limit (IM_LIMIT),
    .fault    (fault)
  );

  // ERET has no delay slot, so whatever sits in F behind it is discarded.
  assign squash      = D_eret || sq_q;
  assign i_inst_addr = pc_q;
  assign F_PC        = pc_q;
  assign F_instr     = (squash || fault) ? 32'd0 : i_inst_rdata;
  assign F_excCode   = (!squash && fault) ? EXC_ADEL : EXC_NONE;
  assign F_BD        = D_is_bj && !D_eret;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (!Stall && !Req && !D_eret && !fault)
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (Stall && !Req)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
